quarter_accum: RTL and testbench
================================

# quarter_accum

Downstream accumulation stage for the bitbrick fused multiplier. It consumes the 16-bit packed product word each cycle and unpacks it into 1, 2 or 4 lanes according to the precision mode. Each lane is summed into a wide per-lane accumulator across a dot-product group, and the group result is presented over a valid/ready handshake to the output buffer. It sits between the multiplier array and the output-activation writeback.

## Interface
- ACC_W, 24, per-lane accumulator width in bits (≥ 8)
- CNT_W, 10, beat-counter width; maximum group length is 2^CNT_W − 1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  product beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  16  packed product word from the multiplier
- in_mode  in  2  0 = 1 lane (16-bit), 1 = 2 lanes (bytes), 2 = 4 lanes (nibbles), 3 = reserved
- in_signed  in  1  lanes interpreted as two's complement when 1, else zero-extended
- in_last  in  1  final beat of the group
- out_valid  out  1  group result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  4*ACC_W  lane k at [k*ACC_W +: ACC_W]; unused lanes are 0
- out_mode  out  2  latched mode of the group
- out_count  out  CNT_W  beats accumulated in the group
- out_sat  out  4  per-lane saturation flags (see Configuration)

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- **IDLE:** in_ready = 1. On the first accepted beat:
  - latch in_mode and in_signed;
  - load the accumulators with that beat's lane values (not added to stale contents);
  - set count = 1.
  - Next state is ACCUM, or HOLD if in_last.
- **ACCUM:** in_ready = 1. Each accepted beat adds its lane values to the accumulators and increments count.
  - Leave for HOLD on in_last, or when count reaches 2^CNT_W − 1 (forced close).
  - in_mode and in_signed are ignored after the first beat.
- **HOLD:** in_ready = 0 and out_valid = 1.
  - out_* hold stable until out_ready.
  - On handshake, go to IDLE and clear the accumulators, count and out_sat.
- **Lane extraction:**
  - Mode 0: lane0 = in_data[15:0].
  - Mode 1: lane0 = [7:0], lane1 = [15:8].
  - Mode 2: lane k = in_data[4k+3:4k].
  - Each lane is sign- or zero-extended to ACC_W per the latched signedness.
- Mode 3 beats are accepted and counted but add zero; out_data is 0.
- The first accepted beat in_last = 1 produces a one-beat group.
- Reset in any state: go to IDLE, all accumulators, counts and flags 0, out_valid = 0, in_ready = 1 once reset is deasserted.

## Timing
- in_ready is a registered function of state only. There is no combinational path from out_ready to in_ready.
- Last beat accepted in cycle N gives out_valid = 1 in cycle N+1.
- Minimum throughput: one group per (beats + 1) cycles.
- A beat presented while in HOLD waits. in_valid with its data must be held by the producer until accepted.

## Configuration
- Macro: QUARTER_ACCUM_SAT_EN.
- **Defined:** each lane add saturates.
  - Signed lanes clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; unsigned lanes clamp to 2^ACC_W − 1.
  - The corresponding out_sat bit is set sticky for the group.
- **Undefined:** lanes wrap modulo 2^ACC_W and out_sat is tied to 0.

## Structure
- Package quarter_accum_pkg contains:
  - the mode enum (QA_MODE_1L, QA_MODE_2L, QA_MODE_4L, QA_MODE_RSVD);
  - the FSM state enum;
  - a function lane_extend(word, mode, signed, k) returning ACC_W bits.
- One sub-module, quarter_accum_lane, instantiated ×4. It holds the accumulator register, load vs. add select, and the saturation logic under the macro.
- The top level holds the FSM, beat counter, mode/sign latch and output muxing.

## Test plan
- **Mode 0, signed:** beats 16'hFFF7, 16'h0005 (last) → one cycle later out_valid, lane0 = 24'hFFFFFC (−4), out_count = 2.
- **Mode 1, signed:** beat 16'h0AF6, beat 16'h0101 (last) → lane1 = 11, lane0 = −9; in_mode toggled to 2 on beat 2 has no effect.
- **Mode 2, unsigned:** 16'h4321 twice (last on 2nd) → lanes 0..3 = 2, 4, 6, 8.
- **Backpressure:** hold out_ready = 0 for 3 cycles → out_valid stays 1, out_data stable, in_ready = 0; the next group's first beat is accepted the cycle after the handshake and does not include the old sum.
- **Saturation** (ACC_W = 8, mode 0 signed): beats 100, 100 (last) → with QUARTER_ACCUM_SAT_EN lane0 = 127, out_sat[0] = 1; without it lane0 = −56, out_sat = 0.
- **Boundaries:**
  - CNT_W = 3, seven beats of 1 with no last → forced close, out_count = 7, lane0 = 7.
  - Reset asserted mid-ACCUM → out_valid = 0 and accumulators are 0 immediately; a new group starts from zero.

Source files
------------

// File: rtl/quarter_accum_pkg.sv
// Shared types and lane-unpacking helpers for the quarter_accum accumulation stage.
// Build option: QUARTER_ACCUM_SAT_EN enables saturating lane accumulation.
package quarter_accum_pkg;

    localparam int QA_LANES = 4;
    // A lane is at most 16 bits; one extra bit carries its sign so callers can
    // widen to any accumulator width with a plain signed cast.
    localparam int QA_EXT_W = 17;

    typedef enum logic [1:0] {
        QA_MODE_1L   = 2'd0,
        QA_MODE_2L   = 2'd1,
        QA_MODE_4L   = 2'd2,
        QA_MODE_RSVD = 2'd3
    } qa_mode_e;

    typedef enum logic [1:0] {
        QA_IDLE  = 2'd0,
        QA_ACCUM = 2'd1,
        QA_HOLD  = 2'd2
    } qa_state_e;

    function automatic logic [QA_EXT_W-1:0] lane_extend(
        input logic [15:0] word,
        input qa_mode_e    mode,
        input logic        sgn,
        input logic [1:0]  k
    );
        logic [7:0] byte_v;
        logic [3:0] nib_v;
        logic [QA_EXT_W-1:0] r;
        byte_v = k[0] ? word[15:8] : word[7:0];
        case (k)
            2'd0:    nib_v = word[3:0];
            2'd1:    nib_v = word[7:4];
            2'd2:    nib_v = word[11:8];
            default: nib_v = word[15:12];
        endcase
        r = '0;
        case (mode)
            QA_MODE_1L: if (k == 2'd0) r = {sgn & word[15], word};
            QA_MODE_2L: if (!k[1])     r = {{9{sgn & byte_v[7]}}, byte_v};
            QA_MODE_4L:                r = {{13{sgn & nib_v[3]}}, nib_v};
            default:                   r = '0;
        endcase
        return r;
    endfunction

    // Lanes beyond the mode's lane count are forced to zero at the output.
    function automatic logic lane_used(input qa_mode_e mode, input logic [1:0] k);
        case (mode)
            QA_MODE_1L: return k == 2'd0;
            QA_MODE_2L: return !k[1];
            QA_MODE_4L: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/quarter_accum_lane.sv
// One per-lane accumulator: load on the first beat, add on later beats,
// optional saturation (QUARTER_ACCUM_SAT_EN) with a sticky flag.
module quarter_accum_lane #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             add,
`ifdef QUARTER_ACCUM_SAT_EN
    input  logic             sgn,
`endif
    input  logic [ACC_W-1:0] operand,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);
    import quarter_accum_pkg::*;

    logic [ACC_W-1:0] sum;
    logic             ovf;

`ifdef QUARTER_ACCUM_SAT_EN
    logic [ACC_W:0] wide;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wide = '0;
        ovf  = 1'b0;
        sum  = '0;
        if (sgn) begin
            wide = {acc[ACC_W-1], acc} + {operand[ACC_W-1], operand};
            ovf  = wide[ACC_W] ^ wide[ACC_W-1];
            if (!ovf)
                sum = wide[ACC_W-1:0];
            else if (wide[ACC_W])
                sum = {1'b1, {(ACC_W-1){1'b0}}};
            else
                sum = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            wide = {1'b0, acc} + {1'b0, operand};
            ovf  = wide[ACC_W];
            sum  = ovf ? '1 : wide[ACC_W-1:0];
        end
    end
`else
    assign sum = acc + operand;
    assign ovf = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (load) begin
            acc <= operand;
            sat <= 1'b0;
        end else if (add) begin
            acc <= sum;
            sat <= sat | ovf;
        end
    end

endmodule

// File: rtl/quarter_accum.sv
// Unpacks 16-bit product words into 1/2/4 lanes and accumulates each lane over a
// dot-product group, presenting the result on a valid/ready port (QUARTER_ACCUM_SAT_EN optional).
module quarter_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic [1:0]         in_mode,
    input  logic               in_signed,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] out_data,
    output logic [1:0]         out_mode,
    output logic [CNT_W-1:0]   out_count,
    output logic [3:0]         out_sat
);
    import quarter_accum_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    qa_state_e        state;
    qa_mode_e         mode_q;
    logic             signed_q;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             handshake;
    logic             close;
    logic [CNT_W-1:0] cnt_next;
    qa_mode_e         eff_mode;
    logic             eff_signed;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    // The first beat of a group decodes with its own mode/sign; later beats use the latch.
    assign eff_mode   = (state == QA_IDLE) ? qa_mode_e'(in_mode) : mode_q;
    assign eff_signed = (state == QA_IDLE) ? in_signed : signed_q;
    assign cnt_next   = (state == QA_IDLE) ? CNT_W'(1) : count + 1'b1;
    assign close      = in_last || (cnt_next == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= QA_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            mode_q    <= QA_MODE_1L;
            signed_q  <= 1'b0;
        end else begin
            case (state)
                QA_IDLE, QA_ACCUM: begin
                    if (accept) begin
                        count <= cnt_next;
                        if (state == QA_IDLE) begin
                            mode_q   <= qa_mode_e'(in_mode);
                            signed_q <= in_signed;
                        end
                        if (close) begin
                            state     <= QA_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= QA_ACCUM;
                        end
                    end
                end
                QA_HOLD: begin
                    if (out_ready) begin
                        state     <= QA_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= QA_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < QA_LANES; k++) begin : g_lane
        logic [QA_EXT_W-1:0] ext;
        logic [ACC_W-1:0]    operand;
        logic [ACC_W-1:0]    acc;
        logic                sat;

        assign ext     = lane_extend(in_data, eff_mode, eff_signed, 2'(k));
        assign operand = ACC_W'(signed'(ext));

        quarter_accum_lane #(.ACC_W(ACC_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr     (handshake),
            .load    (accept && (state == QA_IDLE)),
            .add     (accept && (state == QA_ACCUM)),
`ifdef QUARTER_ACCUM_SAT_EN
            .sgn     (eff_signed),
`endif
            .operand (operand),
            .acc     (acc),
            .sat     (sat)
        );

        assign out_data[k*ACC_W +: ACC_W] = lane_used(mode_q, 2'(k)) ? acc : '0;
        assign out_sat[k]                 = lane_used(mode_q, 2'(k)) && sat;
    end

    assign out_mode  = mode_q;
    assign out_count = count;

endmodule

// File: tb/tb_quarter_accum.sv
// Directed self-checking bench for quarter_accum: a default-size instance for the
// lane modes and handshake, and an ACC_W=8/CNT_W=3 instance for saturation and forced close.
module tb_quarter_accum;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, in_signed, in_last;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid, out_ready;
    logic [95:0] out_data;
    logic [1:0]  out_mode;
    logic [9:0]  out_count;
    logic [3:0]  out_sat;

    logic        s_in_valid, s_in_ready, s_in_signed, s_in_last;
    logic [15:0] s_in_data;
    logic [1:0]  s_in_mode;
    logic        s_out_valid, s_out_ready;
    logic [31:0] s_out_data;
    logic [1:0]  s_out_mode;
    logic [2:0]  s_out_count;
    logic [3:0]  s_out_sat;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    quarter_accum dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_count(out_count), .out_sat(out_sat)
    );

    quarter_accum #(.ACC_W(8), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_mode(s_in_mode), .in_signed(s_in_signed), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_mode(s_out_mode), .out_count(s_out_count), .out_sat(s_out_sat)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic sg, input logic last);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m; in_signed = sg; in_last = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1 within 20 cycles");
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic s_send(input logic [15:0] d, input logic sg, input logic last);
        bit ok = 1'b0;
        s_in_valid = 1'b1; s_in_data = d; s_in_mode = 2'd0; s_in_signed = sg; s_in_last = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_in_ready;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $error("FAIL s_send_timeout: observed in_ready=0 expected in_ready=1 within 20 cycles");
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic s_drain();
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; in_mode = '0; in_signed = 0; in_last = 0; out_ready = 0;
        s_in_valid = 0; s_in_data = '0; s_in_mode = '0; s_in_signed = 0; s_in_last = 0; s_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  96'(in_ready),  96'd1);
        check("rst_out_valid", 96'(out_valid), 96'd0);
        check("rst_out_data",  out_data,       96'd0);
        check("rst_out_count", 96'(out_count), 96'd0);
        reset = 1'b0;

        // Mode 0 signed: -9 + 5
        send(16'hFFF7, 2'd0, 1'b1, 1'b0);
        check("m0_mid_valid", 96'(out_valid), 96'd0);
        send(16'h0005, 2'd0, 1'b1, 1'b1);
        check("m0_valid", 96'(out_valid), 96'd1);
        check("m0_data",  out_data, {24'h0, 24'h0, 24'h0, 24'hFFFFFC});
        check("m0_count", 96'(out_count), 96'd2);
        check("m0_mode",  96'(out_mode), 96'd0);
        check("m0_sat",   96'(out_sat), 96'd0);
        check("m0_hold_ready", 96'(in_ready), 96'd0);
        drain();
        check("m0_drain_valid", 96'(out_valid), 96'd0);
        check("m0_drain_ready", 96'(in_ready), 96'd1);

        // Mode 1 signed; mode/sign on beat 2 ignored
        send(16'h0AF6, 2'd1, 1'b1, 1'b0);
        send(16'h0101, 2'd2, 1'b0, 1'b1);
        check("m1_data", out_data, {24'h0, 24'h0, 24'h00000B, 24'hFFFFF7});
        check("m1_mode", 96'(out_mode), 96'd1);
        drain();

        // Mode 2 unsigned, then backpressure with the next beat waiting
        send(16'h4321, 2'd2, 1'b0, 1'b0);
        send(16'h4321, 2'd2, 1'b0, 1'b1);
        check("m2_data",  out_data, {24'd8, 24'd6, 24'd4, 24'd2});
        check("m2_count", 96'(out_count), 96'd2);
        in_valid = 1'b1; in_data = 16'h0003; in_mode = 2'd0; in_signed = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 96'(out_valid), 96'd1);
            check("bp_ready", 96'(in_ready),  96'd0);
            check("bp_data",  out_data, {24'd8, 24'd6, 24'd4, 24'd2});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_after_ready", 96'(in_ready), 96'd1);
        check("bp_after_valid", 96'(out_valid), 96'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_next_valid", 96'(out_valid), 96'd1);
        check("bp_next_data",  out_data, 96'd3);
        check("bp_next_count", 96'(out_count), 96'd1);
        drain();

        // Reserved mode adds zero but counts
        send(16'hFFFF, 2'd3, 1'b1, 1'b0);
        send(16'h1234, 2'd0, 1'b0, 1'b1);
        check("m3_data",  out_data, 96'd0);
        check("m3_count", 96'(out_count), 96'd2);
        check("m3_mode",  96'(out_mode), 96'd3);
        drain();

        // Reset mid-group, then restart from zero
        send(16'h0010, 2'd0, 1'b0, 1'b0);
        send(16'h0020, 2'd0, 1'b0, 1'b0);
        check("rm_count_before", 96'(out_count), 96'd2);
        reset = 1'b1;
        #1;
        check("rm_valid", 96'(out_valid), 96'd0);
        check("rm_data",  out_data, 96'd0);
        check("rm_count", 96'(out_count), 96'd0);
        check("rm_ready", 96'(in_ready), 96'd1);
        reset = 1'b0;
        send(16'h0007, 2'd0, 1'b0, 1'b1);
        check("rm_new_data",  out_data, 96'd7);
        check("rm_new_count", 96'(out_count), 96'd1);
        drain();

        // Saturation on the 8-bit instance: 100 + 100
        s_send(16'h0064, 1'b1, 1'b0);
        s_send(16'h0064, 1'b1, 1'b1);
        check("sat_valid", 96'(s_out_valid), 96'd1);
`ifdef QUARTER_ACCUM_SAT_EN
        check("sat_data", 96'(s_out_data), 96'h7F);
        check("sat_flag", 96'(s_out_sat),  96'd1);
`else
        check("sat_data", 96'(s_out_data), 96'hC8);
        check("sat_flag", 96'(s_out_sat),  96'd0);
`endif
        s_drain();

        // Forced close at 2^3-1 beats with no last
        for (int i = 0; i < 6; i++) s_send(16'h0001, 1'b0, 1'b0);
        check("fc_six_valid", 96'(s_out_valid), 96'd0);
        s_send(16'h0001, 1'b0, 1'b0);
        check("fc_valid", 96'(s_out_valid), 96'd1);
        check("fc_count", 96'(s_out_count), 96'd7);
        check("fc_data",  96'(s_out_data),  96'd7);
        check("fc_ready", 96'(s_in_ready),  96'd0);
        s_drain();
        check("fc_drain_count", 96'(s_out_count), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
